pcecd_phase_ctrl: RTL

PCECD_PHASE_CTRL -- requirements
Module: pcecd_phase_ctrl

---
 rtl/pcecd_phase_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/pcecd_phase_ctrl.sv
`default_nettype none
// ============================================================================
// pcecd_phase_ctrl : PC Engine CD-ROM SCSI target phase sequencer
//   Command capture, REQ/ACK handshakes and the status/message close-out.
// Revision: 1.0
// ============================================================================
module pcecd_phase_ctrl #(
  parameter int CMD_MAX = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sel,
  input  logic       i_ack,
  input  logic       i_bus_rst,
  input  logic [7:0] i_db,
  output logic [7:0] o_db,
  output logic       o_bsy,
  output logic       o_req,
  output logic       o_msg,
  output logic       o_cd,
  output logic       o_io,
  output logic [7:0] o_phase,
  output logic       o_cmd_valid,
  output logic [3:0] o_cmd_len,
  input  logic [3:0] i_cmd_addr,
  output logic [7:0] o_cmd_data,
  input  logic       i_cmd_done,
  input  logic       i_has_data,
  input  logic [7:0] i_status,
  input  logic       i_data_valid,
  input  logic [7:0] i_data,
  input  logic       i_data_last,
  output logic       o_data_ready,
  output logic       o_irq_ready,
  output logic       o_irq_done
);

  typedef enum logic [2:0] {
    ST_BUS_FREE   = 3'd0,
    ST_COMMAND    = 3'd1,
    ST_EXECUTE    = 3'd2,
    ST_DATA_IN    = 3'd3,
    ST_STATUS     = 3'd4,
    ST_MESSAGE_IN = 3'd5
  } state_t;

  localparam logic [7:0] C_CMD_MAX = 8'(CMD_MAX);

  state_t     r_state, w_state_n;
  logic       r_req, w_req_n;
  logic [7:0] r_db, w_db_n;
  logic [3:0] r_cmd_len, w_len_n;
  logic [7:0] r_count, w_count_n;
  logic [7:0] r_status, w_status_n;
  logic       r_last, w_last_n;
  logic       r_bus_rst_d;
  logic       r_cmd_valid, w_cmd_valid_n;
  logic       r_data_ready, w_data_ready_n;
  logic       r_irq_ready, w_irq_ready_n;
  logic       r_irq_done, w_irq_done_n;
  logic       w_wr_en;
  logic [7:0] r_buf [CMD_MAX];

  logic w_take, w_idle, w_bus_rst_rise;
  assign w_take         = r_req & i_ack;
  assign w_idle         = ~r_req & ~i_ack;
  assign w_bus_rst_rise = i_bus_rst & ~r_bus_rst_d;

  always_comb begin
    w_state_n      = r_state;
    w_req_n        = r_req;
    w_db_n         = r_db;
    w_len_n        = r_cmd_len;
    w_count_n      = r_count;
    w_status_n     = r_status;
    w_last_n       = r_last;
    w_cmd_valid_n  = 1'b0;
    w_data_ready_n = 1'b0;
    w_irq_ready_n  = 1'b0;
    w_irq_done_n   = 1'b0;
    w_wr_en        = 1'b0;
    if (w_bus_rst_rise) begin
      w_state_n = ST_BUS_FREE;
      w_req_n   = 1'b0;
      w_count_n = 8'd0;
    end else begin
      case (r_state)
        ST_BUS_FREE: if (i_sel) begin
          w_state_n = ST_COMMAND;
          w_req_n   = 1'b1;
          w_count_n = 8'd0;
          w_len_n   = 4'd6;
        end
        ST_COMMAND: begin
          if (w_take) begin
            w_req_n = 1'b0;
            w_wr_en = (r_count < C_CMD_MAX);
            if (r_count < C_CMD_MAX) w_count_n = r_count + 8'd1;
            if (r_count == 8'd0)
              w_len_n = (i_db[7:5] == 3'd1 || i_db[7:5] == 3'd2 ||
                         i_db[7:3] == 5'b11011) ? 4'd10 : 4'd6;
          end else if (w_idle) begin
            // saturated count also ends the phase so a short buffer cannot stall
            if (r_count >= {4'd0, r_cmd_len} || r_count == C_CMD_MAX) begin
              w_cmd_valid_n = 1'b1;
              w_state_n     = ST_EXECUTE;
            end else begin
              w_req_n = 1'b1;
            end
          end
        end
        ST_EXECUTE: if (i_cmd_done) begin
          w_status_n = i_status;
          w_last_n   = 1'b0;
          if (i_has_data) begin
            w_state_n = ST_DATA_IN;
          end else begin
            w_state_n = ST_STATUS;
            w_db_n    = i_status;
            w_req_n   = 1'b1;
          end
        end
        ST_DATA_IN: begin
          if (w_take) begin
            w_req_n = 1'b0;
          end else if (w_idle && r_last) begin
            w_irq_ready_n = 1'b1;
            w_state_n     = ST_STATUS;
            w_db_n        = r_status;
            w_req_n       = 1'b1;
          end else if (w_idle && i_data_valid) begin
            w_db_n         = i_data;
            w_data_ready_n = 1'b1;
            w_req_n        = 1'b1;
            w_last_n       = i_data_last;
          end
        end
        ST_STATUS: begin
          if (w_take) begin
            w_req_n = 1'b0;
          end else if (w_idle) begin
            w_state_n = ST_MESSAGE_IN;
            w_db_n    = 8'h00;
            w_req_n   = 1'b1;
          end
        end
        ST_MESSAGE_IN: begin
          if (w_take) begin
            w_req_n = 1'b0;
          end else if (w_idle) begin
            w_state_n    = ST_BUS_FREE;
            w_irq_done_n = 1'b1;
          end
        end
        default: begin
          w_state_n = ST_BUS_FREE;
          w_req_n   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_BUS_FREE;
      r_req        <= 1'b0;
      r_db         <= 8'h00;
      r_cmd_len    <= 4'd6;
      r_count      <= 8'd0;
      r_status     <= 8'h00;
      r_last       <= 1'b0;
      r_bus_rst_d  <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_data_ready <= 1'b0;
      r_irq_ready  <= 1'b0;
      r_irq_done   <= 1'b0;
      for (int i = 0; i < CMD_MAX; i++) r_buf[i] <= 8'h00;
    end else begin
      r_state      <= w_state_n;
      r_req        <= w_req_n;
      r_db         <= w_db_n;
      r_cmd_len    <= w_len_n;
      r_count      <= w_count_n;
      r_status     <= w_status_n;
      r_last       <= w_last_n;
      r_bus_rst_d  <= i_bus_rst;
      r_cmd_valid  <= w_cmd_valid_n;
      r_data_ready <= w_data_ready_n;
      r_irq_ready  <= w_irq_ready_n;
      r_irq_done   <= w_irq_done_n;
      for (int i = 0; i < CMD_MAX; i++)
        if (w_wr_en && r_count == 8'(i)) r_buf[i] <= i_db;
    end
  end

  always_comb begin
    o_cmd_data = 8'h00;
    for (int i = 0; i < CMD_MAX; i++)
      if ({4'd0, i_cmd_addr} == 8'(i)) o_cmd_data = r_buf[i];
  end

  always_comb begin
    {o_bsy, o_msg, o_cd, o_io} = 4'b0000;
    o_phase = 8'h00;
    case (r_state)
      ST_COMMAND:    begin {o_bsy, o_msg, o_cd, o_io} = 4'b1010; o_phase = 8'h01; end
      ST_EXECUTE:    begin {o_bsy, o_msg, o_cd, o_io} = 4'b1000; o_phase = 8'h40; end
      ST_DATA_IN:    begin {o_bsy, o_msg, o_cd, o_io} = 4'b1001; o_phase = 8'h02; end
      ST_STATUS:     begin {o_bsy, o_msg, o_cd, o_io} = 4'b1011; o_phase = 8'h08; end
      ST_MESSAGE_IN: begin {o_bsy, o_msg, o_cd, o_io} = 4'b1111; o_phase = 8'h10; end
      default:       begin {o_bsy, o_msg, o_cd, o_io} = 4'b0000; o_phase = 8'h00; end
    endcase
  end

  assign o_req        = r_req;
  assign o_db         = r_db;
  assign o_cmd_len    = r_cmd_len;
  assign o_cmd_valid  = r_cmd_valid;
  assign o_data_ready = r_data_ready;
  assign o_irq_ready  = r_irq_ready;
  assign o_irq_done   = r_irq_done;

endmodule
`default_nettype wire
